control_configuracion: RTL and testbench
========================================

CONTROL_CONFIGURACION -- requirements
Module: control_configuracion

Interface
REQ-001 SHALL have parameter HORA_MAX, default 23, the maximum hour value.
REQ-002 SHALL have parameter MIN_MAX, default 59, the maximum minute and second value.
REQ-003 SHALL have parameter TIMEOUT, default 255, the ack wait limit in clk cycles.
REQ-004 SHALL have port clk  input  1  the single system clock; all logic rises on posedge clk.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable_config  input  1  level; high means edit mode is allowed.
REQ-007 SHALL have ports izquierda, derecha, arriba, abajo  input  1 each  single-cycle pulses from the per-button debounce blocks.
REQ-008 SHALL have port ack_escritura  input  1  acknowledge from the RTC write controller.
REQ-009 SHALL have port campo  output  2  cursor position: 0 hora, 1 minuto, 2 segundo.
REQ-010 SHALL have ports hora (5 bits), minuto (6 bits), segundo (6 bits)  output  binary edited values.
REQ-011 SHALL have port req_escritura  output  1  write request.
REQ-012 SHALL have port dir_escritura  output  2  field being written.
REQ-013 SHALL have port dato_escritura  output  6  value being written, zero-extended.
REQ-014 SHALL have port error_escritura  output  1  one-cycle pulse when an ack times out.

Function
REQ-015 SHALL implement an FSM with states IDLE, EDITAR, ESCRIBIR and ESPERA_BAJA.
REQ-016 IDLE SHALL move to EDITAR when enable_config=1, and SHALL ignore all button pulses.
REQ-017 EDITAR SHALL move to IDLE when enable_config=0, with campo reset to 0 and values retained.
REQ-018 Simultaneous pulses SHALL be resolved by fixed priority izquierda > derecha > arriba > abajo; lower-priority pulses in the same cycle are discarded, not queued.
REQ-019 In EDITAR, izquierda SHALL decrement campo, with 0 wrapping to 2.
REQ-020 In EDITAR, derecha SHALL increment campo, with 2 wrapping to 0.
REQ-021 In EDITAR, arriba SHALL increment the selected field, with max wrapping to 0 (HORA_MAX for hora, MIN_MAX otherwise).
REQ-022 In EDITAR, abajo SHALL decrement the selected field, with 0 wrapping to max.
REQ-023 A value change SHALL update the field register and enter ESCRIBIR on the next edge.
REQ-024 In ESCRIBIR, req_escritura SHALL be 1, with dir_escritura=campo and dato_escritura=new value held stable for the whole state.
REQ-025 ESCRIBIR SHALL move to ESPERA_BAJA on the first cycle ack_escritura=1 is sampled, and req_escritura SHALL drop in that same transition.
REQ-026 ESPERA_BAJA SHALL hold req_escritura=0 and return to EDITAR, or to IDLE if enable_config=0, once ack_escritura=0 is sampled.
REQ-027 Cursor moves SHALL NOT issue writes.
REQ-028 Button pulses in ESCRIBIR and ESPERA_BAJA SHALL be discarded.
REQ-029 enable_config falling during ESCRIBIR or ESPERA_BAJA SHALL NOT abort the handshake.
REQ-030 A timeout counter SHALL run in ESCRIBIR; after TIMEOUT cycles without ack it SHALL pulse error_escritura for 1 cycle, drop req, and enter ESPERA_BAJA.
REQ-031 ack_escritura=1 while the FSM is in IDLE or EDITAR SHALL be ignored.
REQ-032 Write latency SHALL be: arriba pulse at edge N gives req_escritura=1 from edge N+1.

Reset
REQ-033 reset=0 SHALL immediately force: state IDLE, campo=0, hora=minuto=segundo=0, req_escritura=0, dir_escritura=0, dato_escritura=0, error_escritura=0, timeout counter=0.
REQ-034 Reset asserted mid-handshake SHALL drop req_escritura without waiting for ack.

Structure
REQ-035 A shared package SHALL hold the field codes CAMPO_HORA=0, CAMPO_MINUTO=1, CAMPO_SEGUNDO=2 and the FSM state encodings.
REQ-036 One sub-module, contador_campo (parameterised modular up/down counter with load-enable), SHALL be instantiated once per field.

Verification
REQ-037 Reset, enable_config=1, arriba x3 -> hora=3; three write handshakes, each dir_escritura=0, dato_escritura=1,2,3.
REQ-038 campo=0, hora=0, abajo -> hora=23, dato_escritura=23; campo=2, segundo=59, arriba -> segundo=0.
REQ-039 izquierda and arriba in the same cycle at campo=0 -> campo=2, values unchanged, no req_escritura.
REQ-040 ack held 0 after arriba -> req_escritura stays 1 for exactly TIMEOUT cycles, then error_escritura pulses once and req_escritura=0.
REQ-041 enable_config dropped while req_escritura=1, then ack 1 for 1 cycle -> state IDLE, campo=0, values kept.
REQ-042 reset pulsed low while req_escritura=1 -> all outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/control_configuracion_pkg.sv
// Shared types for the time-setting controller:
// field codes, FSM states and cursor helpers.
package control_configuracion_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EDITAR      = 2'd1,
    ESCRIBIR    = 2'd2,
    ESPERA_BAJA = 2'd3
  } estado_t;

  typedef logic [1:0] campo_t;

  localparam campo_t CAMPO_HORA    = 2'd0;
  localparam campo_t CAMPO_MINUTO  = 2'd1;
  localparam campo_t CAMPO_SEGUNDO = 2'd2;

  function automatic campo_t campo_izq(
    input campo_t c
  );
    return (c == CAMPO_HORA) ?
      CAMPO_SEGUNDO : c - 2'd1;
  endfunction

  function automatic campo_t campo_der(
    input campo_t c
  );
    return (c == CAMPO_SEGUNDO) ?
      CAMPO_HORA : c + 2'd1;
  endfunction

endpackage

// File: rtl/control_configuracion_if.sv
// RTC write handshake bundle between the
// configuration controller and the RTC writer.
interface control_configuracion_if;
  import control_configuracion_pkg::*;

  logic       req;
  campo_t     dir;
  logic [5:0] dato;
  logic       ack;
  logic       err;

  modport master (
    output req, dir, dato, err,
    input  ack
  );

  modport slave (
    input  req, dir, dato, err,
    output ack
  );

endinterface

// File: rtl/control_configuracion_contador_campo.sv
// Modular up/down counter with load enable;
// nxt is the stepped value regardless of en.
module contador_campo #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] TOPE = W'(MAX);
  localparam logic [W-1:0] UNO  = W'(1);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    if (up) begin
      nxt = (q_q == TOPE) ? '0 : q_q + UNO;
    end else begin
      nxt = (q_q == '0) ? TOPE : q_q - UNO;
    end
    q_d = en ? nxt : q_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/control_configuracion.sv
// Button-driven hh:mm:ss editor that pushes every
// changed field to the RTC over a req/ack handshake.
module control_configuracion
  import control_configuracion_pkg::*;
#(
  parameter int HORA_MAX = 23,
  parameter int MIN_MAX  = 59,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_config,
  input  logic       izquierda,
  input  logic       derecha,
  input  logic       arriba,
  input  logic       abajo,
  input  logic       ack_escritura,
  output logic [1:0] campo,
  output logic [4:0] hora,
  output logic [5:0] minuto,
  output logic [5:0] segundo,
  output logic       req_escritura,
  output logic [1:0] dir_escritura,
  output logic [5:0] dato_escritura,
  output logic       error_escritura
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_FIN =
    CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_UNO = CW'(1);

  estado_t     st_q, st_d;
  campo_t      campo_q, campo_d;
  campo_t      dir_q, dir_d;
  logic [5:0]  dato_q, dato_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        paso;
  logic        up;
  logic        en_h, en_m, en_s;
  logic [4:0]  nxt_h;
  logic [5:0]  nxt_m, nxt_s;
  logic [5:0]  nxt_sel;

  contador_campo #(
    .W   (5),
    .MAX (HORA_MAX)
  ) u_hora (
    .clk   (clk),
    .rst_n (reset),
    .en    (en_h),
    .up    (up),
    .q     (hora),
    .nxt   (nxt_h)
  );

  contador_campo #(
    .W   (6),
    .MAX (MIN_MAX)
  ) u_minuto (
    .clk   (clk),
    .rst_n (reset),
    .en    (en_m),
    .up    (up),
    .q     (minuto),
    .nxt   (nxt_m)
  );

  contador_campo #(
    .W   (6),
    .MAX (MIN_MAX)
  ) u_segundo (
    .clk   (clk),
    .rst_n (reset),
    .en    (en_s),
    .up    (up),
    .q     (segundo),
    .nxt   (nxt_s)
  );

  always_comb begin
    unique case (campo_q)
      CAMPO_HORA:    nxt_sel = {1'b0, nxt_h};
      CAMPO_MINUTO:  nxt_sel = nxt_m;
      CAMPO_SEGUNDO: nxt_sel = nxt_s;
      default:       nxt_sel = '0;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    campo_d = campo_q;
    dir_d   = dir_q;
    dato_d  = dato_q;
    req_d   = req_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    paso    = 1'b0;
    up      = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (enable_config) st_d = EDITAR;
      end
      EDITAR: begin
        if (!enable_config) begin
          st_d    = IDLE;
          campo_d = CAMPO_HORA;
        end else begin
          // lower-priority pulses are dropped
          priority case (1'b1)
            izquierda:
              campo_d = campo_izq(campo_q);
            derecha:
              campo_d = campo_der(campo_q);
            arriba, abajo: begin
              paso = 1'b1;
              up   = arriba;
            end
            default: ;
          endcase
        end
      end
      ESCRIBIR: begin
        if (ack_escritura) begin
          st_d  = ESPERA_BAJA;
          req_d = 1'b0;
          cnt_d = '0;
        end else if (cnt_q == CNT_FIN) begin
          st_d  = ESPERA_BAJA;
          req_d = 1'b0;
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_UNO;
        end
      end
      ESPERA_BAJA: begin
        if (!ack_escritura) begin
          if (enable_config) begin
            st_d = EDITAR;
          end else begin
            st_d    = IDLE;
            campo_d = CAMPO_HORA;
          end
        end
      end
      default: st_d = IDLE;
    endcase

    en_h = paso && (campo_q == CAMPO_HORA);
    en_m = paso && (campo_q == CAMPO_MINUTO);
    en_s = paso && (campo_q == CAMPO_SEGUNDO);

    if (paso) begin
      st_d   = ESCRIBIR;
      dir_d  = campo_q;
      dato_d = nxt_sel;
      req_d  = 1'b1;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= IDLE;
      campo_q <= CAMPO_HORA;
      dir_q   <= CAMPO_HORA;
      dato_q  <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      campo_q <= campo_d;
      dir_q   <= dir_d;
      dato_q  <= dato_d;
      req_q   <= req_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign campo           = campo_q;
  assign req_escritura   = req_q;
  assign dir_escritura   = dir_q;
  assign dato_escritura  = dato_q;
  assign error_escritura = err_q;

endmodule

// File: tb/tb_control_configuracion.sv
// Randomized scoreboard bench for the time editor;
// a forked monitor pops expected RTC writes.
module tb_control_configuracion;
  import control_configuracion_pkg::*;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic izq = 1'b0, der = 1'b0;
  logic arr = 1'b0, abj = 1'b0;
  logic [1:0] campo;
  logic [4:0] hora;
  logic [5:0] minuto, segundo;

  control_configuracion_if wif();

  control_configuracion #(
    .HORA_MAX (23),
    .MIN_MAX  (59),
    .TIMEOUT  (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable_config   (en),
    .izquierda       (izq),
    .derecha         (der),
    .arriba          (arr),
    .abajo           (abj),
    .ack_escritura   (wif.ack),
    .campo           (campo),
    .hora            (hora),
    .minuto          (minuto),
    .segundo         (segundo),
    .req_escritura   (wif.req),
    .dir_escritura   (wif.dir),
    .dato_escritura  (wif.dato),
    .error_escritura (wif.err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int dir;
    int dato;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int m_campo = 0;
  int m_val[3];
  int m_max[3];
  wr_t exp_q[$];
  logic auto_ack = 1'b1;
  int err_cnt = 0;

  task automatic chk(input string n,
                     input int a,
                     input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               n, a, e);
    end
  endtask

  task automatic pulse(input logic [3:0] m);
    @(posedge clk);
    #1 {izq, der, arr, abj} = m;
    @(posedge clk);
    #1 {izq, der, arr, abj} = 4'b0;
  endtask

  // reference: {izq,der,arr,abj}, fixed priority
  task automatic model_press(input logic [3:0] m);
    int c;
    c = m_campo;
    if (!en) return;
    if (m[3]) begin
      m_campo = (m_campo + 2) % 3;
    end else if (m[2]) begin
      m_campo = (m_campo + 1) % 3;
    end else if (m[1]) begin
      m_val[c] = (m_val[c] + 1) % (m_max[c] + 1);
      exp_q.push_back('{c, m_val[c]});
    end else if (m[0]) begin
      m_val[c] = (m_val[c] == 0) ?
        m_max[c] : m_val[c] - 1;
      exp_q.push_back('{c, m_val[c]});
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      if (!wif.req && !wif.ack) break;
      @(negedge clk);
    end
    chk("handshake_end",
        int'(wif.req | wif.ack), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string t);
    chk({t, "_campo"}, int'(campo), m_campo);
    chk({t, "_hora"}, int'(hora), m_val[0]);
    chk({t, "_minuto"}, int'(minuto), m_val[1]);
    chk({t, "_segundo"}, int'(segundo), m_val[2]);
  endtask

  task automatic press(input logic [3:0] m);
    model_press(m);
    pulse(m);
    wait_done();
    check_state("press");
  endtask

  task automatic check_zero(input string t);
    chk({t, "_campo"}, int'(campo), 0);
    chk({t, "_hora"}, int'(hora), 0);
    chk({t, "_minuto"}, int'(minuto), 0);
    chk({t, "_segundo"}, int'(segundo), 0);
    chk({t, "_req"}, int'(wif.req), 0);
    chk({t, "_dir"}, int'(wif.dir), 0);
    chk({t, "_dato"}, int'(wif.dato), 0);
    chk({t, "_err"}, int'(wif.err), 0);
  endtask

  initial begin
    int n;
    int e0;
    logic req_prev;
    int sd, sdat;
    wr_t w;

    m_val = '{0, 0, 0};
    m_max = '{23, 59, 59};
    wif.ack = 1'b0;
    req_prev = 1'b0;
    sd = 0;
    sdat = 0;

    fork
      forever begin
        @(negedge clk);
        if (auto_ack && wif.req && !wif.ack) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          wif.ack = 1'b1;
          for (int k = 0; k < 50; k++) begin
            if (!wif.req) break;
            @(negedge clk);
          end
          wif.ack = 1'b0;
        end
      end
      forever begin
        @(negedge clk);
        if (wif.req && !req_prev) begin
          chk("write_expected",
              (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wr_dir", int'(wif.dir), w.dir);
            chk("wr_dato", int'(wif.dato), w.dato);
          end
          sd = int'(wif.dir);
          sdat = int'(wif.dato);
        end else if (wif.req) begin
          chk("dir_stable", int'(wif.dir), sd);
          chk("dato_stable", int'(wif.dato), sdat);
        end
        req_prev = wif.req;
      end
      forever begin
        @(negedge clk);
        if (wif.err) err_cnt++;
      end
    join_none

    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 reset = 1'b1;

    // buttons while idle do nothing
    press(4'b0010);
    press(4'b0001);

    en = 1'b1;
    repeat (2) @(negedge clk);

    repeat (3) press(4'b0010);
    chk("hora_three_up", int'(hora), 3);
    repeat (4) press(4'b0001);
    chk("hora_wrap_down", int'(hora), 23);
    press(4'b1000);
    press(4'b0001);
    press(4'b0010);
    chk("seg_wrap_up", int'(segundo), 0);
    press(4'b0100);
    press(4'b1010);
    chk("izq_beats_arr", int'(campo), 2);

    repeat (60) press(4'($urandom_range(0, 15)));
    chk("no_errors_yet", err_cnt, 0);

    // ack withheld: timeout path
    auto_ack = 1'b0;
    e0 = err_cnt;
    model_press(4'b0010);
    pulse(4'b0010);
    n = 0;
    for (int k = 0; k < 3 * TO; k++) begin
      if (!wif.req) break;
      if (n == 5) {der, abj} = 2'b11;
      else {der, abj} = 2'b00;
      @(negedge clk);
      if (wif.req) n++;
    end
    {der, abj} = 2'b00;
    chk("req_cycles", n, TO);
    chk("req_after_to", int'(wif.req), 0);
    wait_done();
    chk("err_pulses", err_cnt - e0, 1);
    check_state("after_timeout");

    // enable dropped mid-handshake
    auto_ack = 1'b1;
    while (m_campo != 1) press(4'b0100);
    auto_ack = 1'b0;
    model_press(4'b0001);
    pulse(4'b0001);
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("req_held_disable", int'(wif.req), 1);
    wif.ack = 1'b1;
    @(negedge clk);
    wif.ack = 1'b0;
    repeat (3) @(negedge clk);
    m_campo = 0;
    check_state("disable_mid");
    press(4'b0010);

    // reset in the middle of a write
    en = 1'b1;
    repeat (2) @(negedge clk);
    model_press(4'b0010);
    pulse(4'b0010);
    repeat (2) @(negedge clk);
    chk("req_before_rst", int'(wif.req), 1);
    #2 reset = 1'b0;
    #1 check_zero("mid_reset");
    m_campo = 0;
    m_val = '{0, 0, 0};
    en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    press(4'b0010);
    check_zero("post_reset_idle");
    en = 1'b1;
    auto_ack = 1'b1;
    repeat (2) @(negedge clk);
    press(4'b0010);
    chk("hora_after_rst", int'(hora), 1);

    repeat (4) @(negedge clk);
    chk("pending_writes", exp_q.size(), 0);
    chk("err_total", err_cnt, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
